// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card/PIN session controller with a small internal
// account database (balance, withdraw, deposit, transfer, logout).
// Optional build macro ATM_LOCKOUT_EN adds per-account bad-PIN lockout.
module atm_session_ctrl #(
    parameter int NUM_ACCTS   = 10,
    parameter int ACC_W       = 12,
    parameter int PIN_W       = 4,
    parameter int BAL_W       = 16,
    parameter int AMT_W       = 11,
    parameter int ACC_BASE    = 2000,
    parameter int INIT_BAL    = 500,
    parameter int TIMEOUT_CYC = 100,
    parameter int MAX_TRIES   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_valid,
    input  logic [ACC_W-1:0] acc_num,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    input  logic [AMT_W-1:0] amount,
    input  logic [ACC_W-1:0] dest_acc,
    input  logic             exit,
    output logic             logged_in,
    output logic             resp_valid,
    output logic             error,
    output logic [2:0]       err_code,
    output logic [BAL_W-1:0] balance
);

    localparam int IDX_W  = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_UNKNOWN  = 3'd1;
    localparam logic [2:0] ERR_BAD_PIN  = 3'd2;
    localparam logic [2:0] ERR_INSUFF   = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;
    localparam logic [2:0] ERR_BAD_DEST = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd6;
    localparam logic [2:0] ERR_BAD_CMD  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_PIN_WAIT = 3'd2,
        S_AUTH     = 3'd3,
        S_MENU     = 3'd4,
        S_EXEC     = 3'd5,
        S_RESP     = 3'd6
    } state_t;

    // Offset of an account number from the database base; a value below
    // the base wraps to a huge number and therefore misses the range test.
    function automatic logic [31:0] acct_diff(input logic [ACC_W-1:0] a);
        return 32'(a) - 32'(ACC_BASE);
    endfunction

    state_t             r_state, w_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [PIN_W-1:0]   r_pin;
    logic [IDX_W-1:0]   r_idx;
    logic [2:0]         r_cmd;
    logic [AMT_W-1:0]   r_amt;
    logic [ACC_W-1:0]   r_dest;
    logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
    logic               r_ret_idle, w_ret_idle_nxt;
    logic [BAL_W-1:0]   r_bal [NUM_ACCTS];

    logic               r_logged_in, r_resp_valid, r_error;
    logic [2:0]         r_err_code;
    logic [BAL_W-1:0]   r_balance;

    logic               w_rv_nxt;
    logic [2:0]         w_err_nxt;
    logic [BAL_W-1:0]   w_bal_nxt;
    logic               w_li_nxt;
    logic               w_wr_src, w_wr_dst;
    logic [BAL_W-1:0]   w_src_val, w_dst_val;

    logic [31:0]        w_lk_diff, w_dst_diff;
    logic               w_lk_hit, w_dst_hit, w_pin_ok, w_locked;
    logic [IDX_W-1:0]   w_lk_off, w_dst_off;
    logic [BAL_W-1:0]   w_cur, w_dst_cur, w_amt_ext, w_sub;
    logic [BAL_W:0]     w_dep_sum, w_xfer_sum;

    assign w_lk_diff  = acct_diff(r_acc);
    assign w_lk_hit   = (w_lk_diff < 32'(NUM_ACCTS));
    assign w_lk_off   = w_lk_diff[IDX_W-1:0];
    assign w_pin_ok   = (r_pin == w_lk_diff[PIN_W-1:0]);
    assign w_dst_diff = acct_diff(r_dest);
    assign w_dst_hit  = (w_dst_diff < 32'(NUM_ACCTS));
    assign w_dst_off  = w_dst_diff[IDX_W-1:0];
    assign w_cur      = r_bal[r_idx];
    assign w_dst_cur  = w_dst_hit ? r_bal[w_dst_off] : {BAL_W{1'b0}};
    assign w_amt_ext  = BAL_W'(r_amt);
    assign w_sub      = w_cur - w_amt_ext;
    assign w_dep_sum  = {1'b0, w_cur} + {1'b0, w_amt_ext};
    assign w_xfer_sum = {1'b0, w_dst_cur} + {1'b0, w_amt_ext};

`ifdef ATM_LOCKOUT_EN
    logic [FAIL_W-1:0]    r_fail [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] r_lock;
    logic                 w_auth_ok, w_auth_fail;

    assign w_locked    = r_lock[w_lk_off];
    assign w_auth_ok   = (r_state == S_AUTH) && !exit && w_pin_ok;
    assign w_auth_fail = (r_state == S_AUTH) && !exit && !w_pin_ok;

    // Consecutive bad-PIN counters; the last allowed failure locks the account until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                r_fail[i] <= {FAIL_W{1'b0}};
            end
            r_lock <= {NUM_ACCTS{1'b0}};
        end else if (w_auth_ok) begin
            r_fail[r_idx] <= {FAIL_W{1'b0}};
        end else if (w_auth_fail) begin
            if (r_fail[r_idx] >= FAIL_W'(MAX_TRIES - 1)) begin
                r_lock[r_idx] <= 1'b1;
            end else begin
                r_fail[r_idx] <= r_fail[r_idx] + FAIL_W'(1);
            end
        end
    end
`else
    assign w_locked = 1'b0;
`endif

    // Next-state, response and database-write decode; exit overrides everything.
    always_comb begin
        w_nxt          = r_state;
        w_tmo_nxt      = r_tmo;
        w_ret_idle_nxt = r_ret_idle;
        w_rv_nxt       = 1'b0;
        w_err_nxt      = r_err_code;
        w_bal_nxt      = r_balance;
        w_wr_src       = 1'b0;
        w_wr_dst       = 1'b0;
        w_src_val      = w_cur;
        w_dst_val      = w_dst_cur;
        if (exit && (r_state != S_IDLE)) begin
            w_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (card_valid) begin
                        w_nxt = S_LOOKUP;
                    end else begin
                        w_nxt = S_IDLE;
                    end
                end
                S_LOOKUP: begin
                    if (!w_lk_hit) begin
                        w_nxt = S_RESP; w_ret_idle_nxt = 1'b1;
                        w_rv_nxt = 1'b1; w_err_nxt = ERR_UNKNOWN;
                    end else if (w_locked) begin
                        w_nxt = S_RESP; w_ret_idle_nxt = 1'b1;
                        w_rv_nxt = 1'b1; w_err_nxt = ERR_BAD_PIN;
                    end else begin
                        w_nxt = S_PIN_WAIT; w_tmo_nxt = {TMO_W{1'b0}};
                    end
                end
                S_PIN_WAIT, S_MENU: begin
                    if ((r_state == S_PIN_WAIT) && pin_valid) begin
                        w_nxt = S_AUTH; w_tmo_nxt = {TMO_W{1'b0}};
                    end else if ((r_state == S_MENU) && cmd_valid) begin
                        w_nxt = S_EXEC; w_tmo_nxt = {TMO_W{1'b0}};
                    end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
                        w_nxt = S_RESP; w_ret_idle_nxt = 1'b1;
                        w_rv_nxt = 1'b1; w_err_nxt = ERR_TIMEOUT;
                    end else begin
                        w_tmo_nxt = r_tmo + TMO_W'(1);
                    end
                end
                S_AUTH: begin
                    if (w_pin_ok) begin
                        w_nxt = S_MENU; w_tmo_nxt = {TMO_W{1'b0}};
                        w_rv_nxt = 1'b1; w_err_nxt = ERR_OK; w_bal_nxt = w_cur;
                    end else begin
                        w_nxt = S_RESP; w_ret_idle_nxt = 1'b1;
                        w_rv_nxt = 1'b1; w_err_nxt = ERR_BAD_PIN;
                    end
                end
                S_EXEC: begin
                    w_nxt = S_RESP; w_ret_idle_nxt = 1'b0;
                    w_rv_nxt = 1'b1; w_err_nxt = ERR_OK; w_bal_nxt = w_cur;
                    case (r_cmd)
                        3'd0: begin
                            w_err_nxt = ERR_OK;
                        end
                        3'd1: begin
                            if (w_amt_ext > w_cur) begin
                                w_err_nxt = ERR_INSUFF;
                            end else begin
                                w_wr_src = 1'b1; w_src_val = w_sub; w_bal_nxt = w_sub;
                            end
                        end
                        3'd2: begin
                            if (w_dep_sum[BAL_W]) begin
                                w_err_nxt = ERR_OVERFLOW;
                            end else begin
                                w_wr_src = 1'b1; w_src_val = w_dep_sum[BAL_W-1:0];
                                w_bal_nxt = w_dep_sum[BAL_W-1:0];
                            end
                        end
                        3'd3: begin
                            if (!w_dst_hit || (w_dst_off == r_idx)) begin
                                w_err_nxt = ERR_BAD_DEST;
                            end else if (w_amt_ext > w_cur) begin
                                w_err_nxt = ERR_INSUFF;
                            end else if (w_xfer_sum[BAL_W]) begin
                                w_err_nxt = ERR_OVERFLOW;
                            end else begin
                                w_wr_src = 1'b1; w_src_val = w_sub; w_bal_nxt = w_sub;
                                w_wr_dst = 1'b1; w_dst_val = w_xfer_sum[BAL_W-1:0];
                            end
                        end
                        3'd4: begin
                            w_ret_idle_nxt = 1'b1;
                        end
                        default: begin
                            w_err_nxt = ERR_BAD_CMD;
                        end
                    endcase
                end
                S_RESP: begin
                    if (r_ret_idle) begin
                        w_nxt = S_IDLE;
                    end else begin
                        w_nxt = S_MENU; w_tmo_nxt = {TMO_W{1'b0}};
                    end
                end
                default: begin
                    w_nxt = S_IDLE;
                end
            endcase
        end
        w_li_nxt = (w_nxt == S_MENU) || (w_nxt == S_EXEC) ||
                   ((w_nxt == S_RESP) && !w_ret_idle_nxt);
    end

    // State, inactivity counter and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tmo        <= {TMO_W{1'b0}};
            r_ret_idle   <= 1'b0;
            r_logged_in  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= 3'd0;
            r_balance    <= {BAL_W{1'b0}};
        end else begin
            r_state      <= w_nxt;
            r_tmo        <= w_tmo_nxt;
            r_ret_idle   <= w_ret_idle_nxt;
            r_logged_in  <= w_li_nxt;
            r_resp_valid <= w_rv_nxt;
            r_error      <= (w_err_nxt != 3'd0);
            r_err_code   <= w_err_nxt;
            r_balance    <= w_bal_nxt;
        end
    end

    // Capture of the strobed request fields in the state that accepts them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= {ACC_W{1'b0}};
            r_idx  <= {IDX_W{1'b0}};
            r_pin  <= {PIN_W{1'b0}};
            r_cmd  <= 3'd0;
            r_amt  <= {AMT_W{1'b0}};
            r_dest <= {ACC_W{1'b0}};
        end else begin
            if ((r_state == S_IDLE) && card_valid) begin
                r_acc <= acc_num;
            end
            if (r_state == S_LOOKUP) begin
                r_idx <= w_lk_off;
            end
            if ((r_state == S_PIN_WAIT) && pin_valid) begin
                r_pin <= pin;
            end
            if ((r_state == S_MENU) && cmd_valid) begin
                r_cmd  <= cmd;
                r_amt  <= amount;
                r_dest <= dest_acc;
            end
        end
    end

    // Account balances; a transfer debits and credits on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                r_bal[i] <= BAL_W'(INIT_BAL);
            end
        end else begin
            if (w_wr_src) begin
                r_bal[r_idx] <= w_src_val;
            end
            if (w_wr_dst) begin
                r_bal[w_dst_off] <= w_dst_val;
            end
        end
    end

    assign logged_in  = r_logged_in;
    assign resp_valid = r_resp_valid;
    assign error      = r_error;
    assign err_code   = r_err_code;
    assign balance    = r_balance;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl (default parameters).
// Build with ATM_LOCKOUT_EN defined to exercise the lockout scenario.
module tb_atm_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        card_valid = 1'b0;
    logic [11:0] acc_num = 12'd0;
    logic        pin_valid = 1'b0;
    logic [3:0]  pin = 4'd0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic [10:0] amount = 11'd0;
    logic [11:0] dest_acc = 12'd0;
    logic        exit = 1'b0;
    logic        logged_in, resp_valid, error;
    logic [2:0]  err_code;
    logic [15:0] balance;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        string       nm;
        logic [2:0]  err;
        logic [15:0] bal;
        bit          chk_bal;
        logic        li;
        int          at;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;

    atm_session_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .card_valid(card_valid), .acc_num(acc_num),
        .pin_valid(pin_valid), .pin(pin),
        .cmd_valid(cmd_valid), .cmd(cmd), .amount(amount), .dest_acc(dest_acc),
        .exit(exit),
        .logged_in(logged_in), .resp_valid(resp_valid), .error(error),
        .err_code(err_code), .balance(balance)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Response monitor: pop expectations and compare on every resp_valid.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && resp_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got err_code=%0d balance=%0d at cycle %0d, required no response",
                         err_code, balance, cyc);
            end else begin
                mon_x = q.pop_front();
                if (err_code !== mon_x.err || error !== (mon_x.err != 3'd0) ||
                    logged_in !== mon_x.li || (mon_x.chk_bal && balance !== mon_x.bal) ||
                    cyc != mon_x.at) begin
                    errors++;
                    $display("FAIL %s: got err=%0d error=%0b bal=%0d li=%0b cyc=%0d, required err=%0d bal=%0d(chk=%0b) li=%0b cyc=%0d",
                             mon_x.nm, err_code, error, balance, logged_in, cyc,
                             mon_x.err, mon_x.bal, mon_x.chk_bal, mon_x.li, mon_x.at);
                end
            end
        end
    end

    function automatic void push(string nm, logic [2:0] e, logic [15:0] b, bit cb, logic li, int at);
        exp_t x;
        x.nm = nm; x.err = e; x.bal = b; x.chk_bal = cb; x.li = li; x.at = at;
        q.push_back(x);
    endfunction

    task automatic drive_card(input logic [11:0] a, input bit has, input logic [2:0] e, input string nm);
        @(negedge clk);
        acc_num = a; card_valid = 1'b1;
        if (has) push(nm, e, 16'd0, 1'b0, 1'b0, cyc + 2);
        @(negedge clk);
        card_valid = 1'b0;
    endtask

    task automatic drive_pin(input logic [3:0] p, input logic [2:0] e, input logic [15:0] b, input string nm);
        @(negedge clk);
        pin = p; pin_valid = 1'b1;
        push(nm, e, b, (e == 3'd0), (e == 3'd0), cyc + 2);
        @(negedge clk);
        pin_valid = 1'b0;
    endtask

    task automatic drive_cmd(input logic [2:0] c, input logic [10:0] amt, input logic [11:0] d,
                             input logic [2:0] e, input logic [15:0] b, input logic li, input string nm);
        @(negedge clk);
        cmd = c; amount = amt; dest_acc = d; cmd_valid = 1'b1;
        push(nm, e, b, 1'b1, li, cyc + 2);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        for (int i = 0; i < budget && q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d responses still outstanding, required 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic login(input logic [11:0] a, input logic [3:0] p, input logic [15:0] b, input string nm);
        drive_card(a, 1'b0, 3'd0, nm);
        drive_pin(p, 3'd0, b, nm);
        wait_drain(8, nm);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({logged_in, resp_valid, error, err_code, balance} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: got li=%0b rv=%0b err=%0b code=%0d bal=%0d, required all 0",
                     logged_in, resp_valid, error, err_code, balance);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (logged_in !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got li=%0b rv=%0b, required 0 0", logged_in, resp_valid);
        end
    endtask

    task automatic test_login_balance;
        login(12'd2003, 4'd3, 16'd500, "login_2003");
        drive_cmd(3'd0, 11'd0, 12'd0, 3'd0, 16'd500, 1'b1, "balance_2003");
        wait_drain(8, "balance_2003");
    endtask

    task automatic test_withdraw_deposit;
        logic [15:0] b;
        drive_cmd(3'd1, 11'd200, 12'd0, 3'd0, 16'd300, 1'b1, "withdraw_200");
        wait_drain(8, "w200");
        drive_cmd(3'd1, 11'd400, 12'd0, 3'd3, 16'd300, 1'b1, "withdraw_insuff");
        wait_drain(8, "w400");
        drive_cmd(3'd1, 11'd0, 12'd0, 3'd0, 16'd300, 1'b1, "withdraw_zero");
        wait_drain(8, "w0");
        drive_cmd(3'd2, 11'd1000, 12'd0, 3'd0, 16'd1300, 1'b1, "deposit_1000");
        wait_drain(8, "d1000");
        b = 16'd1300;
        for (int i = 0; i < 31; i++) begin
            b = b + 16'd2047;
            drive_cmd(3'd2, 11'd2047, 12'd0, 3'd0, b, 1'b1, "deposit_fill");
            wait_drain(8, "fill");
        end
        drive_cmd(3'd2, 11'd778, 12'd0, 3'd0, 16'd65535, 1'b1, "deposit_to_max");
        wait_drain(8, "dmax");
        drive_cmd(3'd2, 11'd1, 12'd0, 3'd4, 16'd65535, 1'b1, "deposit_overflow");
        wait_drain(8, "dovf");
        drive_cmd(3'd4, 11'd0, 12'd0, 3'd0, 16'd65535, 1'b0, "logout_2003");
        wait_drain(8, "lo2003");
        @(negedge clk);
        checks++;
        if (logged_in !== 1'b0) begin
            errors++;
            $display("FAIL logged_out_2003: got li=%0b, required 0", logged_in);
        end
    endtask

    task automatic test_transfer;
        login(12'd2001, 4'd1, 16'd500, "login_2001");
        drive_cmd(3'd3, 11'd150, 12'd2009, 3'd0, 16'd350, 1'b1, "xfer_150");
        wait_drain(8, "x150");
        drive_cmd(3'd3, 11'd10, 12'd2001, 3'd5, 16'd350, 1'b1, "xfer_self");
        wait_drain(8, "xself");
        drive_cmd(3'd3, 11'd10, 12'd1999, 3'd5, 16'd350, 1'b1, "xfer_1999");
        wait_drain(8, "x1999");
        drive_cmd(3'd3, 11'd2000, 12'd2010, 3'd5, 16'd350, 1'b1, "xfer_order");
        wait_drain(8, "xorder");
        drive_cmd(3'd3, 11'd400, 12'd2009, 3'd3, 16'd350, 1'b1, "xfer_insuff");
        wait_drain(8, "xins");
        drive_cmd(3'd5, 11'd0, 12'd0, 3'd7, 16'd350, 1'b1, "bad_cmd");
        wait_drain(8, "badcmd");
        drive_cmd(3'd4, 11'd0, 12'd0, 3'd0, 16'd350, 1'b0, "logout_2001");
        wait_drain(8, "lo2001");
        login(12'd2009, 4'd9, 16'd650, "login_2009");
        drive_cmd(3'd4, 11'd0, 12'd0, 3'd0, 16'd650, 1'b0, "logout_2009");
        wait_drain(8, "lo2009");
    endtask

    task automatic test_timeout;
        login(12'd2005, 4'd5, 16'd500, "login_2005");
        push("menu_timeout", 3'd6, 16'd500, 1'b1, 1'b0, cyc + 100);
        wait_drain(130, "timeout");
        @(negedge clk);
        checks++;
        if (logged_in !== 1'b0) begin
            errors++;
            $display("FAIL timeout_logout: got li=%0b, required 0", logged_in);
        end
        drive_card(12'd2500, 1'b1, 3'd1, "unknown_2500");
        wait_drain(8, "u2500");
        drive_card(12'd2006, 1'b0, 3'd0, "card_2006");
        drive_pin(4'd7, 3'd2, 16'd0, "bad_pin_2006");
        wait_drain(8, "bp2006");
        login(12'd2006, 4'd6, 16'd500, "login_2006");
        drive_cmd(3'd4, 11'd0, 12'd0, 3'd0, 16'd500, 1'b0, "logout_2006");
        wait_drain(8, "lo2006");
    endtask

    task automatic test_exit_back_to_back;
        login(12'd2004, 4'd4, 16'd500, "login_2004");
        @(negedge clk);
        cmd = 3'd0; amount = 11'd0; cmd_valid = 1'b1;
        push("b2b_first", 3'd0, 16'd500, 1'b1, 1'b1, cyc + 2);
        @(negedge clk);
        cmd = 3'd1; amount = 11'd100;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_drain(8, "b2b");
        drive_cmd(3'd0, 11'd0, 12'd0, 3'd0, 16'd500, 1'b1, "b2b_ignored");
        wait_drain(8, "b2b2");
        @(negedge clk);
        cmd = 3'd1; amount = 11'd100; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; exit = 1'b1;
        @(negedge clk);
        exit = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (logged_in !== 1'b0) begin
            errors++;
            $display("FAIL exit_logout: got li=%0b, required 0", logged_in);
        end
        login(12'd2004, 4'd4, 16'd500, "relogin_2004");
        drive_cmd(3'd4, 11'd0, 12'd0, 3'd0, 16'd500, 1'b0, "logout_2004");
        wait_drain(8, "lo2004");
    endtask

`ifdef ATM_LOCKOUT_EN
    task automatic test_lockout;
        for (int i = 0; i < 3; i++) begin
            drive_card(12'd2002, 1'b0, 3'd0, "card_2002");
            drive_pin(4'd5, 3'd2, 16'd0, "lock_bad_pin");
            wait_drain(8, "lbp");
        end
        drive_card(12'd2002, 1'b1, 3'd2, "locked_card");
        wait_drain(8, "locked");
        @(negedge clk);
        pin = 4'd2; pin_valid = 1'b1;
        @(negedge clk);
        pin_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        login(12'd2002, 4'd2, 16'd500, "unlock_login");
    endtask
`else
    task automatic test_lockout;
        for (int i = 0; i < 4; i++) begin
            drive_card(12'd2002, 1'b0, 3'd0, "card_2002");
            drive_pin(4'd5, 3'd2, 16'd0, "retry_bad_pin");
            wait_drain(8, "rbp");
        end
        login(12'd2002, 4'd2, 16'd500, "retry_login");
    endtask
`endif

    initial begin
        test_reset();
        test_login_balance();
        test_withdraw_deposit();
        test_transfer();
        test_timeout();
        test_exit_back_to_back();
        test_lockout();
        repeat (4) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d outstanding, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
